// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC generator, 1-cycle IMEM requester and DEPTH-entry prefetch FIFO.
// Latency: redirect/reset at t -> imem_req t+1 -> enqueue t+2 -> deq_valid t+3; 1 instr/cycle sustained.
// Backpressure: deq_ready=0 holds the head; requests are credit-limited so responses never overflow.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h4000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [XLEN-1:0]            deq_instr,
    output logic [XLEN-1:0]            deq_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_pipe;
    logic            inflight;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] mem_instr [DEPTH];
    logic [XLEN-1:0] mem_pc    [DEPTH];

    logic            deq_fire;
    logic            enq;
    logic [CW:0]     credit_need;

    // Redirect target low bits are forced to zero, so they carry no information.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = &{1'b0, redirect_pc[1:0]};

    // Head presentation, handshake and credit-limited request issue.
    always_comb begin
        deq_valid   = (count != '0) & ~redirect_valid & ~reset;
        deq_fire    = deq_valid & deq_ready;
        deq_instr   = mem_instr[rd_ptr];
        deq_pc      = mem_pc[rd_ptr];
        // An entry leaving this cycle frees a slot for a request issued this cycle.
        credit_need = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(deq_fire);
        imem_req    = ~reset & ~redirect_valid & (credit_need < (CW+1)'(DEPTH));
        imem_addr   = fetch_pc;
        enq         = inflight & ~redirect_valid;
        occupancy   = reset ? '0 : count;
    end

    // Control state: PC, in-flight tracking, pointers and count; redirect outranks everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            pc_pipe  <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc <= fetch_pc + XLEN'(4);
                pc_pipe  <= fetch_pc;
            end
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(enq) - CW'(deq_fire);
        end
    end

    // Buffer storage; contents are only meaningful below count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            mem_instr[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]    <= pc_pipe;
        end
    end
endmodule
